// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    CORE_DLY  = 3'd2,
    RUN       = 3'd3,
    SW_HOLD   = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  // Largest of three values; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop single-bit synchronizer with asynchronous active-low clear.
module sync_bit #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  // Shift the async input one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged peripheral/core reset release gated on a stable PLL lock.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned CORE_DELAY         = 16,
  parameter int unsigned SW_RST_CYCLES      = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       sw_rst_req,
  output logic       periph_rst_n,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [1:0] rst_cause,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned CNT_MAX = max3(LOCK_STABLE_CYCLES, CORE_DELAY, SW_RST_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_CYCLES - 1);

  logic             lock_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             periph_rst_n_q, periph_rst_n_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic [1:0]       rst_cause_q, rst_cause_d;
  logic [7:0]       lock_loss_cnt_q, lock_loss_cnt_d;
  logic             lock_loss;

  sync_bit #(.N(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state, cause tracking, counter and registered output decode.
  always_comb begin
    state_d         = state_q;
    rst_cause_d     = rst_cause_q;
    lock_loss_cnt_d = lock_loss_cnt_q;
    lock_loss       = 1'b0;

    unique case (state_q)
      WAIT_LOCK: if (lock_s) state_d = STABLE;
      STABLE: begin
        // A drop before the stable window completes just restarts the wait.
        if (!lock_s)                 state_d = WAIT_LOCK;
        else if (cnt_q == LOCK_LAST) state_d = CORE_DLY;
      end
      CORE_DLY: begin
        if (!lock_s)                 lock_loss = 1'b1;
        else if (cnt_q == CORE_LAST) state_d = RUN;
      end
      RUN: begin
        // Lock loss takes priority over a simultaneous software request.
        if (!lock_s) begin
          lock_loss = 1'b1;
        end else if (sw_rst_req) begin
          state_d     = SW_HOLD;
          rst_cause_d = CAUSE_SW;
        end
      end
      SW_HOLD: begin
        // Lock was held throughout, so skip the stable wait afterwards.
        if (!lock_s)               lock_loss = 1'b1;
        else if (cnt_q == SW_LAST) state_d = CORE_DLY;
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (lock_loss) begin
      state_d         = WAIT_LOCK;
      rst_cause_d     = CAUSE_LOCK;
      lock_loss_cnt_d = (lock_loss_cnt_q == 8'hFF) ? 8'hFF : lock_loss_cnt_q + 8'd1;
    end

    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q == STABLE || state_q == CORE_DLY || state_q == SW_HOLD)
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = cnt_q;

    periph_rst_n_d = (state_d == CORE_DLY) || (state_d == RUN);
    sys_rst_n_d    = (state_d == RUN);
    ready_d        = (state_d == RUN);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      periph_rst_n_q  <= 1'b0;
      sys_rst_n_q     <= 1'b0;
      ready_q         <= 1'b0;
      rst_cause_q     <= CAUSE_POR;
      lock_loss_cnt_q <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      periph_rst_n_q  <= periph_rst_n_d;
      sys_rst_n_q     <= sys_rst_n_d;
      ready_q         <= ready_d;
      rst_cause_q     <= rst_cause_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

  assign periph_rst_n  = periph_rst_n_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign rst_cause     = rst_cause_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer (SYNC=2, STABLE=8, CORE=4, SW=6).
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic       sw_rst_req;
  logic       periph_rst_n;
  logic       sys_rst_n;
  logic       ready;
  logic [1:0] rst_cause;
  logic [7:0] lock_loss_cnt;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    int unsigned cyc;
    logic [12:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];

  pll_reset_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .CORE_DELAY         (4),
    .SW_RST_CYCLES      (6)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_lock      (pll_lock),
    .sw_rst_req    (sw_rst_req),
    .periph_rst_n  (periph_rst_n),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .rst_cause     (rst_cause),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  // Edge number: after the n-th rising edge, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [12:0] ev(input logic p, input logic s, input logic r,
                                     input logic [1:0] c, input logic [7:0] n);
    return {p, s, r, c, n};
  endfunction

  task automatic push(input int unsigned at, input logic [12:0] v, input string tag);
    exp_t e;
    e.cyc = at; e.v = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  // Compare scheduled expectations once the DUT has reached that edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, {19'd0, periph_rst_n, sys_rst_n, ready, rst_cause, lock_loss_cnt},
            {19'd0, e.v});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got cyc %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned e0, k, s;
    int unsigned n;

    reset_n = 1'b0; pll_lock = 1'b0; sw_rst_req = 1'b0;
    #3;
    check("por_periph", periph_rst_n, 0);
    check("por_sys",    sys_rst_n, 0);
    check("por_ready",  ready, 0);
    check("por_cause",  rst_cause, 0);
    check("por_cnt",    lock_loss_cnt, 0);

    // 1: power-up release
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    pll_lock = 1'b1; e0 = cyc + 1;
    push(e0 + 9,  ev(0, 0, 0, 2'b00, 8'd0), "pu_pre_periph");
    push(e0 + 10, ev(1, 0, 0, 2'b00, 8'd0), "pu_periph");
    push(e0 + 13, ev(1, 0, 0, 2'b00, 8'd0), "pu_pre_sys");
    push(e0 + 14, ev(1, 1, 1, 2'b00, 8'd0), "pu_run");
    wait_cyc(e0 + 15);

    // 2: unstable lock restarts the stable wait without counting a loss
    reset_n = 1'b0; pll_lock = 1'b0;
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    pll_lock = 1'b1; e0 = cyc + 1;
    push(e0 + 5,  ev(0, 0, 0, 2'b00, 8'd0), "glitch_low");
    push(e0 + 15, ev(0, 0, 0, 2'b00, 8'd0), "glitch_pre_periph");
    push(e0 + 16, ev(1, 0, 0, 2'b00, 8'd0), "glitch_periph");
    push(e0 + 20, ev(1, 1, 1, 2'b00, 8'd0), "glitch_run");
    wait_cyc(e0 + 4); pll_lock = 1'b0;
    wait_cyc(e0 + 5); pll_lock = 1'b1;
    wait_cyc(e0 + 21);

    // 3: lock loss in RUN, then full re-lock
    pll_lock = 1'b0; k = cyc + 1;
    push(k + 1, ev(1, 1, 1, 2'b00, 8'd0), "loss_pre");
    push(k + 2, ev(0, 0, 0, 2'b01, 8'd1), "loss_drop");
    wait_cyc(k + 4);
    pll_lock = 1'b1; e0 = cyc + 1;
    push(e0 + 9,  ev(0, 0, 0, 2'b01, 8'd1), "relock_pre");
    push(e0 + 10, ev(1, 0, 0, 2'b01, 8'd1), "relock_periph");
    push(e0 + 14, ev(1, 1, 1, 2'b01, 8'd1), "relock_run");
    wait_cyc(e0 + 15);

    // 4: software reset, with a second request ignored during SW_HOLD
    sw_rst_req = 1'b1; s = cyc + 1;
    push(s,      ev(0, 0, 0, 2'b10, 8'd1), "sw_assert");
    push(s + 5,  ev(0, 0, 0, 2'b10, 8'd1), "sw_hold_end");
    push(s + 6,  ev(1, 0, 0, 2'b10, 8'd1), "sw_periph");
    push(s + 9,  ev(1, 0, 0, 2'b10, 8'd1), "sw_pre_sys");
    push(s + 10, ev(1, 1, 1, 2'b10, 8'd1), "sw_run");
    @(negedge clk); sw_rst_req = 1'b0;
    wait_cyc(s + 2); sw_rst_req = 1'b1;
    @(negedge clk); sw_rst_req = 1'b0;
    wait_cyc(s + 11);

    // 5: lock loss and sw request together; lock loss wins
    pll_lock = 1'b0; k = cyc + 1;
    push(k + 1, ev(1, 1, 1, 2'b10, 8'd1), "simul_pre");
    push(k + 2, ev(0, 0, 0, 2'b01, 8'd2), "simul_lock_wins");
    wait_cyc(k + 1); sw_rst_req = 1'b1;
    wait_cyc(k + 2); sw_rst_req = 1'b0;

    // 5b: repeated losses from CORE_DLY saturate the counter
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1; e0 = cyc + 1;
      wait_cyc(e0 + 10);
      pll_lock = 1'b0; k = cyc + 1;
      n = 3 + i;
      if (n > 255) n = 255;
      push(k + 2, ev(0, 0, 0, 2'b01, 8'(n)), "sat_cnt");
      wait_cyc(k + 2);
    end

    // 6: async reset in the middle of CORE_DLY
    pll_lock = 1'b1; e0 = cyc + 1;
    push(e0 + 9,  ev(0, 0, 0, 2'b01, 8'd255), "ar_pre");
    push(e0 + 10, ev(1, 0, 0, 2'b01, 8'd255), "ar_core_dly");
    wait_cyc(e0 + 11);
    #1 reset_n = 1'b0;
    #1;
    check("ar_periph", periph_rst_n, 0);
    check("ar_sys",    sys_rst_n, 0);
    check("ar_ready",  ready, 0);
    check("ar_cause",  rst_cause, 0);
    check("ar_cnt",    lock_loss_cnt, 0);

    @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
